// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS core
//
// Ports:
//   i_clk, i_rst       clock (rising edge), asynchronous active-high reset
//   i_instrCode        opcode field of the instruction register
//   i_memReady         unified memory completes the current access this cycle
//   o_state            FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=7
//   o_memRead/Write    memory strobes; o_iorD selects PC(0) or ALU out(1) as address
//   o_irWrite          instruction register load
//   o_pcWrite          unconditional PC load; o_beq/o_bne conditional loads
//   o_pcSrc            0=ALU, 1=ALU out register, 2=jump target
//   o_aluSrcA/B        ALU operand selects; o_aluOp in opcode encoding (6'h09 = add)
//   o_extOp            1=sign extend, 0=zero extend
//   o_regDst           1=rd, 0=rt; o_memToReg 1=MDR, 0=ALU out; o_regWrite
//   o_instrDone        pulse on the last cycle of each instruction
//   o_busErr           sticky memory timeout flag
module multicycle_control #(
    parameter int WAIT_MAX = 15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_instrCode,
    input  logic       i_memReady,
    output logic [2:0] o_state,
    output logic       o_memRead,
    output logic       o_memWrite,
    output logic       o_iorD,
    output logic       o_irWrite,
    output logic       o_pcWrite,
    output logic       o_beq,
    output logic       o_bne,
    output logic [1:0] o_pcSrc,
    output logic       o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [5:0] o_aluOp,
    output logic       o_extOp,
    output logic       o_regDst,
    output logic       o_memToReg,
    output logic       o_regWrite,
    output logic       o_instrDone,
    output logic       o_busErr
);

    localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam bit TIMEOUT_EN = (WAIT_MAX > 0);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] ALU_ADD  = 6'h09;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    state_t         state;
    state_t         nextState;
    logic [5:0]     opReg;
    logic [WCW-1:0] waitCnt;
    logic           busErr;

    logic isRType, isImm, isLoad, isStore, isBranch, isJump, codeLegal;
    logic memPhase, timeout;

    // Decode of the latched opcode; valid from EXEC onwards.
    assign isRType  = (opReg == OP_RTYPE);
    assign isImm    = (opReg inside {OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI});
    assign isLoad   = (opReg == OP_LW);
    assign isStore  = (opReg == OP_SW);
    assign isBranch = (opReg == OP_BEQ) || (opReg == OP_BNE);
    assign isJump   = (opReg == OP_J);

    // DECODE decides legality from the live IR field since opReg loads at its end.
    assign codeLegal = (i_instrCode inside {OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
                                            OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW});

    assign memPhase = (state == S_FETCH) || (state == S_MEM);
    // A ready on the would-be timeout cycle wins: the access completes.
    assign timeout  = TIMEOUT_EN && memPhase && !i_memReady && (waitCnt == WAIT_LAST);

    assign o_state  = state;
    assign o_busErr = busErr;

    always_comb begin
        nextState   = state;
        o_memRead   = 1'b0;
        o_memWrite  = 1'b0;
        o_iorD      = 1'b0;
        o_irWrite   = 1'b0;
        o_pcWrite   = 1'b0;
        o_beq       = 1'b0;
        o_bne       = 1'b0;
        o_pcSrc     = 2'd0;
        o_aluSrcA   = 1'b0;
        o_aluSrcB   = 2'd0;
        o_aluOp     = ALU_ADD;
        o_extOp     = 1'b0;
        o_regDst    = 1'b0;
        o_memToReg  = 1'b0;
        o_regWrite  = 1'b0;
        o_instrDone = 1'b0;
        // Reset holds every strobe low even though the state already reads FETCH.
        if (!i_rst) begin
            case (state)
                S_FETCH: begin
                    o_memRead = 1'b1;
                    o_aluSrcB = 2'd1;
                    if (i_memReady) begin
                        o_irWrite = 1'b1;
                        o_pcWrite = 1'b1;
                        nextState = S_DECODE;
                    end else if (timeout) begin
                        nextState = S_HALT;
                    end
                end
                S_DECODE: begin
                    o_aluSrcB = 2'd3;
                    o_extOp   = 1'b1;
                    if (codeLegal) begin
                        nextState = S_EXEC;
                    end else begin
                        o_instrDone = 1'b1;
                        nextState   = S_FETCH;
                    end
                end
                S_EXEC: begin
                    if (isRType) begin
                        o_aluSrcA = 1'b1;
                        o_aluOp   = opReg;
                        nextState = S_WB;
                    end else if (isImm) begin
                        o_aluSrcA = 1'b1;
                        o_aluSrcB = 2'd2;
                        o_aluOp   = opReg;
                        o_extOp   = (opReg == OP_ADDI) || (opReg == OP_ADDIU);
                        nextState = S_WB;
                    end else if (isLoad || isStore) begin
                        o_aluSrcA = 1'b1;
                        o_aluSrcB = 2'd2;
                        o_extOp   = 1'b1;
                        nextState = S_MEM;
                    end else if (isBranch) begin
                        o_aluSrcA   = 1'b1;
                        o_aluOp     = opReg;
                        o_pcSrc     = 2'd1;
                        o_beq       = (opReg == OP_BEQ);
                        o_bne       = (opReg == OP_BNE);
                        o_instrDone = 1'b1;
                        nextState   = S_FETCH;
                    end else if (isJump) begin
                        o_pcWrite   = 1'b1;
                        o_pcSrc     = 2'd2;
                        o_instrDone = 1'b1;
                        nextState   = S_FETCH;
                    end else begin
                        nextState = S_FETCH;
                    end
                end
                S_MEM: begin
                    o_iorD     = 1'b1;
                    o_memRead  = isLoad;
                    o_memWrite = isStore;
                    if (i_memReady) begin
                        if (isLoad) begin
                            nextState = S_WB;
                        end else begin
                            o_instrDone = 1'b1;
                            nextState   = S_FETCH;
                        end
                    end else if (timeout) begin
                        nextState = S_HALT;
                    end
                end
                S_WB: begin
                    o_regWrite  = 1'b1;
                    o_instrDone = 1'b1;
                    o_regDst    = isRType;
                    o_memToReg  = isLoad;
                    nextState   = S_FETCH;
                end
                S_HALT: nextState = S_HALT;
                default: nextState = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_FETCH;
            opReg   <= 6'd0;
            waitCnt <= '0;
            busErr  <= 1'b0;
        end else begin
            state <= nextState;
            if (state == S_DECODE) begin
                opReg <= i_instrCode;
            end
            // Counting only stalled FETCH/MEM cycles leaves it zero on every entry.
            if (memPhase && !i_memReady) begin
                waitCnt <= waitCnt + 1'b1;
            end else begin
                waitCnt <= '0;
            end
            if (timeout) begin
                busErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       i_clk;
    logic       i_rst;
    logic [5:0] i_instrCode;
    logic       i_memReady;
    logic [2:0] o_state;
    logic       o_memRead, o_memWrite, o_iorD, o_irWrite, o_pcWrite, o_beq, o_bne;
    logic [1:0] o_pcSrc;
    logic       o_aluSrcA;
    logic [1:0] o_aluSrcB;
    logic [5:0] o_aluOp;
    logic       o_extOp, o_regDst, o_memToReg, o_regWrite, o_instrDone, o_busErr;

    int checks   = 0;
    int failures = 0;

    multicycle_control #(.WAIT_MAX(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_instrCode(i_instrCode), .i_memReady(i_memReady),
        .o_state(o_state), .o_memRead(o_memRead), .o_memWrite(o_memWrite), .o_iorD(o_iorD),
        .o_irWrite(o_irWrite), .o_pcWrite(o_pcWrite), .o_beq(o_beq), .o_bne(o_bne),
        .o_pcSrc(o_pcSrc), .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB), .o_aluOp(o_aluOp),
        .o_extOp(o_extOp), .o_regDst(o_regDst), .o_memToReg(o_memToReg),
        .o_regWrite(o_regWrite), .o_instrDone(o_instrDone), .o_busErr(o_busErr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [23:0] ctlVec;
    assign ctlVec = {o_memRead, o_memWrite, o_iorD, o_irWrite, o_pcWrite, o_beq, o_bne,
                     o_pcSrc, o_aluSrcA, o_aluSrcB, o_aluOp, o_extOp, o_regDst,
                     o_memToReg, o_regWrite, o_instrDone, o_busErr};

    typedef struct {
        int ph;
        bit rdy;
    } cyc_t;

    logic [5:0] legalOps [12] = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E,
                                  6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        foreach (legalOps[k]) if (legalOps[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Control word the instruction table calls for in a given phase.
    function automatic logic [23:0] expCtl(input int ph, input logic [5:0] op, input bit rdy,
                                           input bit berr);
        bit mr = 0, mw = 0, iord = 0, irw = 0, pcw = 0, beq = 0, bne = 0;
        bit asa = 0, ext = 0, rdst = 0, m2r = 0, rw = 0, done = 0;
        logic [1:0] pcs = 2'd0, asb = 2'd0;
        logic [5:0] aop = 6'h09;
        bit isR   = (op == 6'h00);
        bit isImm = op inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        bit isLw  = (op == 6'h23);
        bit isSw  = (op == 6'h2B);
        bit isBr  = (op == 6'h04) || (op == 6'h05);
        bit isJ   = (op == 6'h02);
        case (ph)
            0: begin mr = 1; asb = 2'd1; irw = rdy; pcw = rdy; end
            1: begin asb = 2'd3; ext = 1; done = !legal(op); end
            2: begin
                if (isR) begin asa = 1; aop = op; end
                if (isImm) begin asa = 1; asb = 2'd2; aop = op; ext = (op == 6'h08) || (op == 6'h09); end
                if (isLw || isSw) begin asa = 1; asb = 2'd2; ext = 1; end
                if (isBr) begin asa = 1; aop = op; pcs = 2'd1; beq = (op == 6'h04); bne = (op == 6'h05); done = 1; end
                if (isJ) begin pcw = 1; pcs = 2'd2; done = 1; end
            end
            3: begin iord = 1; mr = isLw; mw = isSw; done = isSw && rdy; end
            4: begin rw = 1; done = 1; rdst = isR; m2r = isLw; end
            default: ;
        endcase
        return {mr, mw, iord, irw, pcw, beq, bne, pcs, asa, asb, aop, ext, rdst, m2r, rw, done, berr};
    endfunction

    task automatic do_reset();
        i_rst = 1'b1;
        #1;
        chk("reset_state", 32'(o_state), 32'd0);
        chk("reset_ctl", 32'(ctlVec), 32'(expCtl(7, 6'h00, 1'b0, 1'b0)));
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    // Runs one instruction from FETCH; fw/mw are stall cycles before ready in FETCH/MEM.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        cyc_t q[$];
        cyc_t r;
        int lat, i;
        bit seen;
        bit isMem = (op == 6'h23) || (op == 6'h2B);
        for (int k = 0; k < fw; k++) q.push_back('{0, 1'b0});
        q.push_back('{0, 1'b1});
        q.push_back('{1, 1'($urandom_range(0, 1))});
        if (legal(op)) begin
            q.push_back('{2, 1'($urandom_range(0, 1))});
            if (isMem) begin
                for (int k = 0; k < mw; k++) q.push_back('{3, 1'b0});
                q.push_back('{3, 1'b1});
            end
            if (op == 6'h23 || !(isMem || op inside {6'h02, 6'h04, 6'h05}))
                q.push_back('{4, 1'($urandom_range(0, 1))});
        end
        if (!legal(op))                          lat = 2;
        else if (op inside {6'h02, 6'h04, 6'h05}) lat = 3;
        else if (op == 6'h23)                    lat = 5;
        else                                     lat = 4;
        lat += fw + (isMem ? mw : 0);

        i = 0;
        seen = 1'b0;
        while (!seen && i < 40) begin
            if (i < q.size()) r = q[i];
            else begin r.ph = 0; r.rdy = 1'b1; end
            i_memReady  = r.rdy;
            i_instrCode = (r.ph <= 1) ? op : 6'($urandom);
            #4;
            chk($sformatf("state op=%02h cyc=%0d", op, i), 32'(o_state), 32'(r.ph));
            chk($sformatf("ctl op=%02h cyc=%0d", op, i), 32'(ctlVec), 32'(expCtl(r.ph, op, r.rdy, 1'b0)));
            if (o_instrDone) seen = 1'b1;
            i++;
            @(posedge i_clk);
            #1;
        end
        chk($sformatf("latency op=%02h fw=%0d mw=%0d", op, fw, mw), 32'(i), 32'(lat));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] op;
        i_rst = 1'b1;
        i_instrCode = 6'h00;
        i_memReady = 1'b0;
        do_reset();

        run_instr(6'h00, 0, 0);
        run_instr(6'h23, 0, 2);
        run_instr(6'h04, 0, 0);
        run_instr(6'h05, 0, 0);
        run_instr(6'h0D, 0, 0);
        run_instr(6'h08, 0, 0);
        run_instr(6'h3F, 0, 0);
        run_instr(6'h2B, 1, 1);
        run_instr(6'h0F, 3, 0);
        run_instr(6'h23, 3, 3);
        run_instr(6'h02, 2, 0);

        // Reset asserted in the middle of a stalled store.
        i_memReady = 1'b1;
        i_instrCode = 6'h2B;
        repeat (3) begin
            @(posedge i_clk);
            #1;
        end
        i_memReady = 1'b0;
        #2;
        chk("midmem_state", 32'(o_state), 32'd3);
        chk("midmem_ctl", 32'(ctlVec), 32'(expCtl(3, 6'h2B, 1'b0, 1'b0)));
        i_rst = 1'b1;
        #1;
        chk("midmem_rst_state", 32'(o_state), 32'd0);
        chk("midmem_rst_ctl", 32'(ctlVec), 32'(expCtl(7, 6'h00, 1'b0, 1'b0)));
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        run_instr(6'h09, 0, 0);

        // Fetch that never completes: four stalls then HALT with a sticky error.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            i_memReady = 1'b0;
            #4;
            chk($sformatf("to_fetch_state c=%0d", c), 32'(o_state), 32'd0);
            chk($sformatf("to_fetch_ctl c=%0d", c), 32'(ctlVec), 32'(expCtl(0, 6'h00, 1'b0, 1'b0)));
            @(posedge i_clk);
            #1;
        end
        for (int c = 0; c < 3; c++) begin
            i_memReady = 1'($urandom_range(0, 1));
            #4;
            chk($sformatf("halt_state c=%0d", c), 32'(o_state), 32'd7);
            chk($sformatf("halt_ctl c=%0d", c), 32'(ctlVec), 32'(expCtl(7, 6'h00, 1'b0, 1'b1)));
            @(posedge i_clk);
            #1;
        end
        do_reset();

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = 6'($urandom); while (legal(op));
            end else begin
                op = legalOps[$urandom_range(0, 11)];
            end
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
